// File: rtl/instr_fetch_sequencer_pkg.sv
// rtl/instr_fetch_sequencer_pkg.sv - shared sequencer state encodings, opcodes and decode helper
package instr_fetch_sequencer_pkg;

    // Encodings are shared with the execute datapath; keep values stable.
    typedef enum logic [3:0] {
        STATE_HLT    = 4'd0,
        STATE_FETCH0 = 4'd1,
        STATE_FETCH1 = 4'd2,
        STATE_EXEC   = 4'd3,
        STATE_ERR    = 4'd4,
        STATE_WAIT   = 4'd5
    } state_e;

    localparam logic [7:0] OP_LIMM16 = 8'h01;
    localparam logic [7:0] OP_LIMM32 = 8'h02;
    localparam logic [7:0] OP_END    = 8'hFF;

    function automatic logic is_two_word(input logic [7:0] op);
        return op == OP_LIMM32;
    endfunction

endpackage

// File: rtl/instr_fetch_sequencer_fetch_wait_timer.sv
// rtl/instr_fetch_sequencer_fetch_wait_timer.sv - counts fetch cycles without mem_valid, flags expiry
module instr_fetch_sequencer_fetch_wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Expiry fires on the LIMIT-th consecutive empty cycle, so the owner can leave that same cycle.
    assign expired = en && (count_q == CNT_W'(LIMIT - 1));

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/instr_fetch_sequencer.sv
// rtl/instr_fetch_sequencer.sv - instruction fetch sequencer; FETCH_SINGLE_STEP_EN adds step input and STATE_WAIT
module instr_fetch_sequencer
    import instr_fetch_sequencer_pkg::*;
#(
    parameter int PC_W        = 16,
    parameter int ROM_LAT_MAX = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
`ifdef FETCH_SINGLE_STEP_EN
    input  logic            step,
`endif
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    input  logic [31:0]     mem_rdata,
    input  logic            mem_valid,
    output logic [31:0]     instr0,
    output logic [31:0]     instr1,
    output logic [3:0]      current_state,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            err
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     instr0_q, instr0_d;
    logic [31:0]     instr1_q, instr1_d;
    logic            err_q, err_d;

    logic fetching;
    logic accept;
    logic timer_expired;

    // Request is a pure function of state so a zero-latency memory can answer in the first cycle.
    assign fetching = (state_q == STATE_FETCH0) || (state_q == STATE_FETCH1);
    assign accept   = fetching && mem_valid;

    instr_fetch_sequencer_fetch_wait_timer #(
        .LIMIT (ROM_LAT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (!fetching || mem_valid),
        .en      (fetching && !mem_valid),
        .expired (timer_expired)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr0_d = instr0_q;
        instr1_d = instr1_q;
        err_d    = err_q;
        case (state_q)
            STATE_HLT: begin
                if (start) begin
                    state_d = STATE_FETCH0;
                end
            end
            STATE_FETCH0: begin
                if (accept) begin
                    instr0_d = mem_rdata;
                    instr1_d = '0;
                    pc_d     = pc_q + 1'b1;
                    state_d  = is_two_word(mem_rdata[31:24]) ? STATE_FETCH1 : STATE_EXEC;
                end else if (timer_expired) begin
                    state_d = STATE_ERR;
                    err_d   = 1'b1;
                end
            end
            STATE_FETCH1: begin
                if (accept) begin
                    instr1_d = mem_rdata;
                    pc_d     = pc_q + 1'b1;
                    state_d  = STATE_EXEC;
                end else if (timer_expired) begin
                    state_d = STATE_ERR;
                    err_d   = 1'b1;
                end
            end
            STATE_EXEC: begin
                if (instr0_q[31:24] == OP_END) begin
                    state_d = STATE_HLT;
                end else begin
`ifdef FETCH_SINGLE_STEP_EN
                    state_d = STATE_WAIT;
`else
                    state_d = STATE_FETCH0;
`endif
                end
            end
`ifdef FETCH_SINGLE_STEP_EN
            STATE_WAIT: begin
                if (step) begin
                    state_d = STATE_FETCH0;
                end
            end
`endif
            STATE_ERR: begin
                state_d = STATE_ERR;
            end
            default: begin
                state_d = STATE_HLT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= STATE_HLT;
            pc_q     <= '0;
            instr0_q <= '0;
            instr1_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr0_q <= instr0_d;
            instr1_q <= instr1_d;
            err_q    <= err_d;
        end
    end

    assign mem_req       = fetching;
    assign mem_addr      = pc_q;
    assign instr0        = instr0_q;
    assign instr1        = instr1_q;
    assign current_state = state_q;
    assign pc            = pc_q;
    assign halted        = (state_q == STATE_HLT) || (state_q == STATE_ERR);
    assign err           = err_q;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// tb/tb_instr_fetch_sequencer.sv - randomized self-checking bench for instr_fetch_sequencer
module tb_instr_fetch_sequencer;
    import instr_fetch_sequencer_pkg::*;

    localparam int PC_W    = 4;
    localparam int LAT_MAX = 15;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
`ifdef FETCH_SINGLE_STEP_EN
    logic            step;
`endif
    logic            mem_req;
    logic [PC_W-1:0] mem_addr;
    logic [31:0]     mem_rdata;
    logic            mem_valid;
    logic [31:0]     instr0;
    logic [31:0]     instr1;
    logic [3:0]      current_state;
    logic [PC_W-1:0] pc;
    logic            halted;
    logic            err;

    always #5 clk = ~clk;

    instr_fetch_sequencer #(
        .PC_W        (PC_W),
        .ROM_LAT_MAX (LAT_MAX)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
`ifdef FETCH_SINGLE_STEP_EN
        .step          (step),
`endif
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .mem_valid     (mem_valid),
        .instr0        (instr0),
        .instr1        (instr1),
        .current_state (current_state),
        .pc            (pc),
        .halted        (halted),
        .err           (err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [3:0]      st;
        logic            chk;
        logic [31:0]     i0;
        logic [31:0]     i1;
        logic [PC_W-1:0] pcv;
    } exp_t;

    logic [31:0]     mem [16];
    int              lat_q[$];
    exp_t            trace[$];
    logic [PC_W-1:0] m_pc;

    function automatic void push_st(input logic [3:0] s, input int n);
        exp_t e;
        e.st = s; e.chk = 1'b0; e.i0 = '0; e.i1 = '0; e.pcv = '0;
        for (int i = 0; i < n; i++) trace.push_back(e);
    endfunction

    function automatic int pick_lat(input int fixed_lat, input int lat_hi);
        return (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, lat_hi));
    endfunction

    // Reference: walk the program from the model's own pc, expanding each instruction into cycles.
    function automatic void build_trace(input int fixed_lat, input int lat_hi);
        logic [31:0] w0, w1;
        int          l;
        exp_t        e;
        for (int n = 0; n < 40; n++) begin
            w0 = mem[m_pc];
            l = pick_lat(fixed_lat, lat_hi);
            lat_q.push_back(l);
            push_st(STATE_FETCH0, l + 1);
            m_pc = m_pc + 1'b1;
            w1 = '0;
            if (w0[31:24] == OP_LIMM32) begin
                l = pick_lat(fixed_lat, lat_hi);
                lat_q.push_back(l);
                push_st(STATE_FETCH1, l + 1);
                w1 = mem[m_pc];
                m_pc = m_pc + 1'b1;
            end
            e.st = STATE_EXEC; e.chk = 1'b1; e.i0 = w0; e.i1 = w1; e.pcv = m_pc;
            trace.push_back(e);
            if (w0[31:24] == OP_END) begin
                push_st(STATE_HLT, 1);
                break;
            end
`ifdef FETCH_SINGLE_STEP_EN
            push_st(STATE_WAIT, 1);
`endif
        end
    endfunction

    task automatic load_random_prog();
        logic [PC_W-1:0] a;
        logic [7:0]      op;
        int              n;
        a = m_pc;
        n = $urandom_range(1, 5);
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
                0:       op = OP_LIMM32;
                1:       op = 8'h40 + 8'($urandom_range(0, 15));
                default: op = OP_LIMM16;
            endcase
            mem[a] = {op, 24'($urandom)};
            a = a + 1'b1;
            if (op == OP_LIMM32) begin
                mem[a] = $urandom;
                a = a + 1'b1;
            end
        end
        mem[a] = {OP_END, 24'($urandom)};
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; mem_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_pc = '0;
        trace.delete();
        lat_q.delete();
    endtask

    task automatic run_trace();
        exp_t e;
        int   w;
        int   cyc;
        w = 0;
        cyc = 0;
        @(negedge clk);
        start = 1'b1;
        while (trace.size() > 0 && cyc < 2000) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            e = trace.pop_front();
            check_val("state", 32'(current_state), 32'(e.st));
            check_val("halted", 32'(halted), 32'((e.st == STATE_HLT) || (e.st == STATE_ERR)));
            if (e.chk) begin
                check_val("instr0", instr0, e.i0);
                check_val("instr1", instr1, e.i1);
                check_val("pc", 32'(pc), 32'(e.pcv));
            end
            if (mem_req) begin
                if (lat_q.size() == 0) begin
                    mem_valid = 1'b0;
                end else if (w == lat_q[0]) begin
                    mem_valid = 1'b1;
                    mem_rdata = mem[mem_addr];
                    void'(lat_q.pop_front());
                    w = 0;
                end else begin
                    mem_valid = 1'b0;
                    w++;
                end
            end else begin
                // Stray responses while idle must be ignored.
                mem_valid = 1'($urandom);
                mem_rdata = $urandom;
            end
        end
        check_val("trace_done", 32'(trace.size()), 32'd0);
        mem_valid = 1'b0;
        trace.delete();
        lat_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
`ifdef FETCH_SINGLE_STEP_EN
        step = 1'b1;
`endif
        for (int i = 0; i < 16; i++) mem[i] = '0;
        do_reset();

        @(negedge clk);
        check_val("rst_state", 32'(current_state), 32'(STATE_HLT));
        check_val("rst_pc", 32'(pc), 32'd0);
        check_val("rst_instr0", instr0, 32'd0);
        check_val("rst_instr1", instr1, 32'd0);
        check_val("rst_mem_req", 32'(mem_req), 32'd0);
        check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst_halted", 32'(halted), 32'd1);

        // LIMM16 then END, zero latency
        mem[0] = {OP_LIMM16, 24'h010005};
        mem[1] = {OP_END, 24'h0};
        build_trace(0, 0);
        run_trace();
        check_val("t1_pc", 32'(pc), 32'd2);
        check_val("t1_halted", 32'(halted), 32'd1);

        // LIMM32 with immediate, latency 3
        do_reset();
        mem[0] = {OP_LIMM32, 24'h020000};
        mem[1] = 32'hDEADBEEF;
        mem[2] = {OP_END, 24'h0};
        build_trace(3, 0);
        run_trace();
        check_val("t2_pc", 32'(pc), 32'd3);

        // Longest tolerated latency
        do_reset();
        mem[0] = {OP_LIMM16, 24'h0};
        mem[1] = {OP_END, 24'h0};
        build_trace(LAT_MAX - 1, 0);
        run_trace();
        check_val("lat_edge_err", 32'(err), 32'd0);

        // pc wrap: park pc at 15, then execute a one-word op there
        do_reset();
        for (int i = 0; i < 14; i++) mem[i] = {OP_LIMM16, 24'(i)};
        mem[14] = {OP_END, 24'h0};
        build_trace(0, 0);
        run_trace();
        check_val("wrap_pre_pc", 32'(pc), 32'd15);
        mem[15] = {OP_LIMM16, 24'h0F0F0F};
        mem[0]  = {OP_END, 24'h0};
        build_trace(0, 0);
        run_trace();
        check_val("wrap_pc", 32'(pc), 32'd1);

        // Randomized programs, continuing from wherever pc lands
        do_reset();
        for (int r = 0; r < 25; r++) begin
            load_random_prog();
            build_trace(-1, 5);
            run_trace();
        end

        // Memory never answers
        do_reset();
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < LAT_MAX; i++) begin
            @(negedge clk);
            start = 1'b0;
            mem_valid = 1'b0;
            check_val("to_fetch", 32'(current_state), 32'(STATE_FETCH0));
        end
        @(negedge clk);
        check_val("to_state", 32'(current_state), 32'(STATE_ERR));
        check_val("to_err", 32'(err), 32'd1);
        check_val("to_mem_req", 32'(mem_req), 32'd0);
        check_val("to_halted", 32'(halted), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_val("to_start_ign", 32'(current_state), 32'(STATE_ERR));
        check_val("to_err_sticky", 32'(err), 32'd1);

        // Reset during FETCH1, then a stray response in HLT
        do_reset();
        mem[0] = {OP_LIMM32, 24'h123456};
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("mr_fetch0", 32'(current_state), 32'(STATE_FETCH0));
        mem_valid = 1'b1;
        mem_rdata = mem[0];
        @(negedge clk);
        mem_valid = 1'b0;
        check_val("mr_fetch1", 32'(current_state), 32'(STATE_FETCH1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("mr_state", 32'(current_state), 32'(STATE_HLT));
        check_val("mr_instr0", instr0, 32'd0);
        check_val("mr_pc", 32'(pc), 32'd0);
        check_val("mr_mem_req", 32'(mem_req), 32'd0);
        mem_valid = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        mem_valid = 1'b0;
        @(negedge clk);
        check_val("mr_stray_state", 32'(current_state), 32'(STATE_HLT));
        check_val("mr_stray_instr0", instr0, 32'd0);
        check_val("mr_stray_instr1", instr1, 32'd0);
        check_val("mr_stray_pc", 32'(pc), 32'd0);
        check_val("mr_stray_err", 32'(err), 32'd0);

`ifdef FETCH_SINGLE_STEP_EN
        begin
            int n_exec;
            do_reset();
            step = 1'b0;
            for (int i = 0; i < 3; i++) mem[i] = {OP_LIMM16, 24'(i)};
            mem[3] = {OP_END, 24'h0};
            n_exec = 0;
            @(negedge clk);
            start = 1'b1;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                start = 1'b0;
                step = (c == 10) || (c == 25);
                if (current_state == STATE_EXEC) n_exec++;
                mem_valid = mem_req;
                mem_rdata = mem[mem_addr];
            end
            mem_valid = 1'b0;
            check_val("step_exec_cnt", 32'(n_exec), 32'd3);
            check_val("step_park", 32'(current_state), 32'(STATE_WAIT));
            check_val("step_halted", 32'(halted), 32'd0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
